// File: rtl/fetch_controller_if.sv
// Fetch-side bus: hazard/branch inputs, instruction-memory handshake and decode-facing buffer.
// master = fetch_controller, slave = the surrounding memory/decode environment.
interface fetch_controller_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        halted;

    modport master (
        input  stall, redirect, redirect_pc, imem_ack, imem_rdata,
        output imem_req, imem_addr, if_valid, if_pc, if_instruction, halted
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_ack, imem_rdata,
        input  imem_req, imem_addr, if_valid, if_pc, if_instruction, halted
    );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: PC owner, single outstanding imem request, one-entry decode buffer.
// Optional FETCH_PERF_CNT_EN adds fetch_count / stall_cycles performance counters.
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    fetch_controller_if.master  bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         fetch_count,
    output logic [31:0]         stall_cycles
`endif
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD, HALT} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_nxt, ifpc_nxt, ins_nxt, redir_tgt;
    logic        ifv_nxt, halt_nxt;

    // imem_addr doubles as the program counter register.
    assign redir_tgt = bus.redirect_pc & ~32'h3;

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            bus.imem_req       <= 1'b0;
            bus.imem_addr      <= RESET_PC;
            bus.if_valid       <= 1'b0;
            bus.if_pc          <= '0;
            bus.if_instruction <= '0;
            bus.halted         <= 1'b0;
        end else begin
            state              <= state_nxt;
            bus.imem_req       <= (state_nxt == REQ);
            bus.imem_addr      <= pc_nxt;
            bus.if_valid       <= ifv_nxt;
            bus.if_pc          <= ifpc_nxt;
            bus.if_instruction <= ins_nxt;
            bus.halted         <= halt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (bus.redirect)      state_nxt = REQ;
                else if (bus.imem_ack) state_nxt = (bus.imem_rdata == '0) ? HALT : HOLD;
            end
            HOLD: if (bus.redirect || !bus.stall) state_nxt = REQ;
            HALT: state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    // Redirect outranks ack/consume; a same-cycle ack is discarded, even a zero word.
    always_comb begin
        pc_nxt   = bus.imem_addr;
        ifv_nxt  = bus.if_valid;
        ifpc_nxt = bus.if_pc;
        ins_nxt  = bus.if_instruction;
        halt_nxt = bus.halted;
        if (state != HALT && bus.redirect) begin
            pc_nxt  = redir_tgt;
            ifv_nxt = 1'b0;
        end else begin
            case (state)
                REQ: begin
                    if (bus.imem_ack) begin
                        if (bus.imem_rdata == '0) begin
                            halt_nxt = 1'b1;
                        end else begin
                            ins_nxt  = bus.imem_rdata;
                            ifpc_nxt = bus.imem_addr;
                            ifv_nxt  = 1'b1;
                            pc_nxt   = bus.imem_addr + 32'd4;
                        end
                    end
                end
                HOLD: if (!bus.stall) ifv_nxt = 1'b0;
                default: ;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count  <= '0;
            stall_cycles <= '0;
        end else begin
            if (state_nxt == HOLD && state != HOLD) fetch_count <= fetch_count + 32'd1;
            if (state == HOLD && bus.stall)         stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequencer for instruction fetch: owns the program counter, issues one request at a time to instruction memory, and presents each fetched word to decode through a one-entry output buffer. It sits between the hazard/branch logic and instruction memory, upstream of decode. It also stops fetching when it reads an all-zero word, which the team uses as the end-of-program marker.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset; must be 4-byte aligned.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  decode not ready; while high, the buffered instruction is held.
- redirect  in  1  taken branch/jump; loads redirect_pc.
- redirect_pc  in  32  target address; bits [1:0] are ignored and treated as 0.
- imem_req  out  1  memory request strobe.
- imem_addr  out  32  request address (current PC).
- imem_ack  in  1  memory response; sampled only while imem_req=1.
- imem_rdata  in  32  instruction word; valid in the same cycle as imem_ack.
- if_valid  out  1  if_instruction/if_pc hold a valid, unconsumed instruction.
- if_pc  out  32  address of the buffered instruction.
- if_instruction  out  32  buffered instruction word.
- halted  out  1  high once the all-zero end marker has been fetched.

## Operation
- State machine with states IDLE, REQ, HOLD, HALT. All outputs are registered.
- IDLE: entered on reset. Moves to REQ unconditionally on the next edge.
- REQ: drives imem_req=1 and imem_addr=pc. On an edge with imem_ack=1 and redirect=0:
  - imem_rdata==0: next state HALT, halted<=1, if_valid stays 0, pc unchanged.
  - otherwise: if_instruction<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4, next state HOLD.
  - Without ack, stays in REQ. The stall input has no effect in REQ.
- HOLD: holds if_valid=1 and imem_req=0. On an edge with stall=0 the instruction is consumed: if_valid<=0, next state REQ. With stall=1, stays in HOLD and holds all outputs.
- HALT: imem_req=0, if_valid=0, halted=1. Only reset leaves HALT. redirect is ignored.
- Redirect, in IDLE/REQ/HOLD: on an edge with redirect=1, pc<={redirect_pc[31:2],2'b00}, if_valid<=0, next state REQ.
  - An imem_ack in the same cycle is discarded; no HALT is triggered even if rdata==0.
  - A buffered instruction in HOLD is dropped regardless of stall.
- Priority at each edge: reset > redirect > ack/consume > hold.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.

## Timing
- During and on the edge after reset=1:
  - outputs: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instruction=0, halted=0.
  - internal: pc=RESET_PC, state IDLE.
- First imem_req=1 appears 1 cycle after reset is deasserted.
- With a zero-wait memory (ack in the request's first cycle) and stall=0, one instruction is delivered every 2 cycles (REQ, HOLD, REQ, ...).
- if_valid rises on the edge that samples ack. Latency from the start of a request to if_valid is (memory wait cycles + 1).
- Redirect-to-new-request latency is 1 cycle; imem_addr shows the target on the next cycle.
- Reset asserted mid-request abandons the request; the memory must tolerate imem_req dropping without ack.

## Configuration
- FETCH_PERF_CNT_EN defined: adds two output ports.
  - fetch_count  out  32: increments on each transition into HOLD.
  - stall_cycles  out  32: increments on each cycle spent in HOLD with stall=1.
  - Both reset to 0, wrap modulo 2^32, and are frozen in HALT.
- FETCH_PERF_CNT_EN undefined: neither port nor counter logic exists; all other behaviour is identical.

## Test plan
- Reset, then memory acks immediately returning 0x00500093, 0x00100113, 0x00000000 → if_pc=0x0, 0x4 presented; halted=1 after the third fetch; imem_req stays 0 afterwards.
- stall held high 5 cycles while in HOLD with if_pc=0x8 → if_valid, if_pc and if_instruction unchanged for 5 cycles; imem_req=0; with FETCH_PERF_CNT_EN, stall_cycles=5.
- redirect=1, redirect_pc=0x103 on the same edge as ack with rdata=0 → no halt, data dropped; the next imem_addr is 0x100.
- redirect during HOLD with stall=1 → if_valid drops on the next cycle; the request to the new PC follows.
- RESET_PC=32'hFFFF_FFFC with one nonzero fetch → the next imem_addr is 0x0000_0000.
- Memory with 3-cycle ack delay, reset asserted in wait cycle 2 → all outputs return to reset values; fetch restarts at RESET_PC.
